// File: rtl/aes_pkg.sv
// Shared definitions for the AES byte-stream loader: size codes, loader states,
// header layout and the key-length helper.
package aes_pkg;

  localparam logic [1:0] SZ_128 = 2'b00;
  localparam logic [1:0] SZ_192 = 2'b01;
  localparam logic [1:0] SZ_256 = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  localparam logic [1:0] ST_HDR = 2'd0;
  localparam logic [1:0] ST_KEY = 2'd1;
  localparam logic [1:0] ST_BLK = 2'd2;
  localparam logic [1:0] ST_OUT = 2'd3;

  localparam int HDR_SIZE_LO = 0;
  localparam int HDR_SIZE_HI = 1;
  localparam int HDR_REUSE   = 2;

  function automatic logic [5:0] key_bytes(input logic [1:0] size);
    case (size)
      SZ_192:  return 6'd24;
      SZ_256:  return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/aes_stream_loader_if.sv
// Byte-stream input and assembled-transaction output of the AES loader.
interface aes_stream_loader_if;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_block;
  logic [255:0] m_key;
  logic [1:0]   m_size;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_block, m_key, m_size
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_block, m_key, m_size
  );
endinterface

// File: rtl/aes_stream_loader.sv
// Assembles header / optional key / plaintext bytes into one registered
// transaction for the combinational cipher stage; keeps the last key for reuse.
module aes_stream_loader
  import aes_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  aes_stream_loader_if.slave  bus,
  output logic                err,
  output logic                key_valid,
  output logic [CNT_W-1:0]    frames
);

  logic [1:0]       state_q,  state_d;
  logic [5:0]       cnt_q,    cnt_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [127:0]     blk_q,    blk_d;
  logic [255:0]     key_q,    key_d;
  logic [1:0]       size_q,   size_d;
  logic             err_q,    err_d;
  logic             kv_q,     kv_d;
  logic [CNT_W-1:0] frames_q, frames_d;

  logic       accept;
  logic [1:0] hdr_size;
  logic       hdr_reuse;

  assign accept    = bus.s_valid && s_ready_q;
  assign hdr_size  = bus.s_data[HDR_SIZE_HI:HDR_SIZE_LO];
  assign hdr_reuse = bus.s_data[HDR_REUSE];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    key_d    = key_q;
    size_d   = size_q;
    kv_d     = kv_q;
    frames_d = frames_q;
    err_d    = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (accept && !flush) begin
          if (hdr_size == SZ_BAD) begin
            err_d = 1'b1;
          end else if (hdr_reuse) begin
            // Reuse is only legal against a complete key of the same size.
            if (!kv_q || hdr_size != size_q) begin
              err_d = 1'b1;
            end else begin
              state_d = ST_BLK;
              cnt_d   = 6'd0;
            end
          end else begin
            size_d  = hdr_size;
            key_d   = '0;
            kv_d    = 1'b0;
            state_d = ST_KEY;
            cnt_d   = 6'd0;
          end
        end
      end
      ST_KEY: begin
        if (flush) begin
          state_d = ST_HDR;
          cnt_d   = 6'd0;
        end else if (accept) begin
          key_d[8'd255 - {cnt_q[4:0], 3'b000} -: 8] = bus.s_data;
          if (cnt_q == key_bytes(size_q) - 6'd1) begin
            kv_d    = 1'b1;
            state_d = ST_BLK;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_BLK: begin
        if (flush) begin
          state_d = ST_HDR;
          cnt_d   = 6'd0;
        end else if (accept) begin
          blk_d[7'd127 - {cnt_q[3:0], 3'b000} -: 8] = bus.s_data;
          if (cnt_q == 6'd15) begin
            state_d = ST_OUT;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        if (bus.m_ready) begin
          frames_d = frames_q + CNT_W'(1);
          state_d  = ST_HDR;
          cnt_d    = 6'd0;
        end
      end
    endcase

    s_ready_d = (state_d != ST_OUT);
    m_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HDR;
      cnt_q     <= 6'd0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      blk_q     <= '0;
      key_q     <= '0;
      size_q    <= SZ_128;
      err_q     <= 1'b0;
      kv_q      <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      blk_q     <= blk_d;
      key_q     <= key_d;
      size_q    <= size_d;
      err_q     <= err_d;
      kv_q      <= kv_d;
      frames_q  <= frames_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_block = blk_q;
  assign bus.m_key   = key_q;
  assign bus.m_size  = size_q;
  assign err         = err_q;
  assign key_valid   = kv_q;
  assign frames      = frames_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed and randomized frames against a byte-level model of the loader.
module tb_aes_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        err;
  logic        key_valid;
  logic [15:0] frames;

  aes_stream_loader_if bus();

  aes_stream_loader #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .err       (err),
    .key_valid (key_valid),
    .frames    (frames)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  kbuf [32];
  logic [7:0]  bbuf [16];
  logic [7:0]  mdl_key [32];
  logic        mdl_kv = 1'b0;
  logic [1:0]  mdl_size = 2'b00;
  logic [15:0] mdl_frames = 16'd0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic got;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    n = 0;
    do begin
      got = bus.s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 50);
    chk1("byte_accept", got, 1'b1);
  endtask

  task automatic abort_byte();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'($urandom);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.s_valid = 1'b0;
  endtask

  // One frame: header, optional key from kbuf, block from bbuf. abort_at is the
  // byte index after the header where a flush (with a byte) is injected, -1 for
  // none. hold < 0 leaves the transaction pending in OUT.
  task automatic do_frame(input logic [7:0] hdr, input int abort_at, input int hold);
    logic [1:0]   sz;
    logic         ru;
    logic         bad;
    int           nk;
    int           total;
    logic [255:0] ek;
    logic [127:0] eb;
    sz  = hdr[1:0];
    ru  = hdr[2];
    bad = (sz == 2'b11) || (ru && (!mdl_kv || sz != mdl_size));
    send_byte(hdr);
    chk1("err_on_header", err, bad);
    if (bad) begin
      bus.s_valid = 1'b0;
      @(posedge clk);
      #1;
      chk1("err_single_pulse", err, 1'b0);
      chk1("mvalid_after_err", bus.m_valid, 1'b0);
      chk1("sready_after_err", bus.s_ready, 1'b1);
      return;
    end
    if (!ru) begin
      mdl_kv   = 1'b0;
      mdl_size = sz;
      nk = (sz == 2'b00) ? 16 : (sz == 2'b01) ? 24 : 32;
      for (int j = 0; j < 32; j++) mdl_key[j] = 8'h00;
    end else begin
      nk = 0;
    end
    total = nk + 16;
    for (int i = 0; i < total; i++) begin
      if (i == abort_at) begin
        abort_byte();
        chk1("kv_after_flush", key_valid, mdl_kv);
        chk1("mvalid_after_flush", bus.m_valid, 1'b0);
        chk1("sready_after_flush", bus.s_ready, 1'b1);
        return;
      end
      if (i == total - 1) chk1("mvalid_not_early", bus.m_valid, 1'b0);
      send_byte(i < nk ? kbuf[i] : bbuf[i - nk]);
      if (i == nk - 1) begin
        mdl_kv = 1'b1;
        for (int j = 0; j < 32; j++) mdl_key[j] = (j < nk) ? kbuf[j] : 8'h00;
        chk1("kv_set_after_key", key_valid, 1'b1);
      end
    end
    bus.s_valid = 1'b0;
    ek = '0;
    for (int j = 0; j < 32; j++) ek = {ek[247:0], mdl_key[j]};
    eb = '0;
    for (int j = 0; j < 16; j++) eb = {eb[119:0], bbuf[j]};
    chk1("mvalid_out", bus.m_valid, 1'b1);
    chk1("sready_out", bus.s_ready, 1'b0);
    chkw("m_key", bus.m_key, ek);
    chkw("m_block", 256'(bus.m_block), 256'(eb));
    chkw("m_size", 256'(bus.m_size), 256'(mdl_size));
    if (hold < 0) return;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
    end
    chk1("mvalid_held", bus.m_valid, 1'b1);
    chk1("sready_held", bus.s_ready, 1'b0);
    chkw("m_block_held", 256'(bus.m_block), 256'(eb));
    chkw("m_key_held", bus.m_key, ek);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    mdl_frames = mdl_frames + 16'd1;
    chkw("frames", 256'(frames), 256'(mdl_frames));
    chk1("mvalid_after_hs", bus.m_valid, 1'b0);
    chk1("sready_after_hs", bus.s_ready, 1'b1);
  endtask

  initial begin
    logic [1:0] sz;
    logic       ru;
    int         ab;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_sready", bus.s_ready, 1'b0);
    chk1("rst_mvalid", bus.m_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_kv", key_valid, 1'b0);
    chkw("rst_frames", 256'(frames), 256'(0));
    chkw("rst_key", bus.m_key, 256'(0));
    chkw("rst_block", 256'(bus.m_block), 256'(0));
    chkw("rst_size", 256'(bus.m_size), 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("sready_rises", bus.s_ready, 1'b1);

    // Illegal size, then reuse without a stored key
    do_frame(8'h03, -1, 0);
    do_frame(8'h04, -1, 0);

    // AES-128 known-answer frame
    for (int i = 0; i < 32; i++) kbuf[i] = 8'(i);
    for (int i = 0; i < 16; i++) bbuf[i] = 8'(i * 17);
    do_frame(8'h00, -1, 0);

    // Reuse of the stored AES-128 key with a new block
    for (int i = 0; i < 16; i++) bbuf[i] = 8'($urandom);
    do_frame(8'h04, -1, 1);

    // Reuse with mismatched size
    do_frame(8'h05, -1, 0);

    // AES-256 frame with back-pressure
    for (int i = 0; i < 32; i++) kbuf[i] = 8'(i);
    do_frame(8'h02, -1, 5);

    // Flush after 10 key bytes, reuse rejected, full frame recovers
    do_frame(8'h01, 10, 0);
    do_frame(8'h05, -1, 0);
    for (int i = 0; i < 32; i++) kbuf[i] = 8'($urandom);
    do_frame(8'h01, -1, 2);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ru = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 32; i++) kbuf[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) bbuf[i] = 8'($urandom);
      ab = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 40)) : -1;
      do_frame({5'($urandom), ru, sz}, ab, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset while a transaction is pending
    for (int i = 0; i < 16; i++) bbuf[i] = 8'($urandom);
    do_frame(8'h00, -1, -1);
    #2;
    rst_n = 1'b0;
    #1;
    mdl_kv = 1'b0;
    mdl_frames = 16'd0;
    chk1("rst_out_mvalid", bus.m_valid, 1'b0);
    chk1("rst_out_kv", key_valid, 1'b0);
    chkw("rst_out_frames", 256'(frames), 256'(mdl_frames));
    chk1("rst_out_sready", bus.s_ready, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
